// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB completer bridge.
package apb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/apb_slave_if.sv
// APB4 bus signals between the interconnect (master) and this bridge (slave).
interface apb_slave_if
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]     paddr;
  logic [2:0]                pprot;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [BYTES_PER_WORD-1:0] pstrb;
  logic                      pready;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_slave.sv
// APB4 completer bridge: registers each APB setup phase into a request for the local
// completer and returns its response onto the bus in the same cycle it arrives.
module apb_slave
  import apb_pkg::*;
#(
  parameter  int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter  int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic                      pclk,
  input  logic                      preset,
  apb_slave_if.slave                apb,
  input  logic                      completer_data_valid,
  input  logic [DATA_WIDTH-1:0]     completer_read_data,
  input  logic                      completer_error,
  output logic [ADDR_WIDTH-1:0]     slave_address,
  output logic [2:0]                slave_protection,
  output logic                      slave_read_write,
  output logic [DATA_WIDTH-1:0]     slave_write_data,
  output logic [BYTES_PER_WORD-1:0] slave_strobe,
  output logic                      slave_data_ready
);

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [2:0]                prot_q, prot_d;
  logic                      write_q, write_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [BYTES_PER_WORD-1:0] strb_q, strb_d;
  logic                      req_q, req_d;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      prot_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      prot_q  <= prot_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    prot_d      = prot_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    req_d       = req_q;
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          addr_d  = apb.paddr;
          prot_d  = apb.pprot;
          write_d = apb.pwrite;
          wdata_d = apb.pwdata;
          strb_d  = apb.pwrite ? apb.pstrb : '0;
          req_d   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Dropping psel before completion is a requester protocol violation: abandon the request.
        if (!apb.psel) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (apb.penable && completer_data_valid) begin
          apb.pready  = 1'b1;
          apb.pslverr = completer_error;
          apb.prdata  = write_q ? '0 : completer_read_data;
          req_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign slave_address    = addr_q;
  assign slave_protection = prot_q;
  assign slave_read_write = write_q;
  assign slave_write_data = wdata_q;
  assign slave_strobe     = strb_q;
  assign slave_data_ready = req_q;

endmodule

// File: tb/tb_apb_slave.sv
// Directed scoreboard bench for apb_slave: stimulus queues expected bus responses,
// a negedge monitor compares them whenever pready is presented.
module tb_apb_slave;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = DW / 8;

  logic          pclk = 1'b0;
  logic          preset;
  logic          cvalid;
  logic [DW-1:0] crdata;
  logic          cerr;
  logic [AW-1:0] s_addr;
  logic [2:0]    s_prot;
  logic          s_rw;
  logic [DW-1:0] s_wdata;
  logic [BW-1:0] s_strb;
  logic          s_rdy;

  int errs   = 0;
  int checks = 0;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } resp_t;

  resp_t exp_q[$];

  apb_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb ();

  apb_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .pclk                 (pclk),
    .preset               (preset),
    .apb                  (apb),
    .completer_data_valid (cvalid),
    .completer_read_data  (crdata),
    .completer_error      (cerr),
    .slave_address        (s_addr),
    .slave_protection     (s_prot),
    .slave_read_write     (s_rw),
    .slave_write_data     (s_wdata),
    .slave_strobe         (s_strb),
    .slave_data_ready     (s_rdy)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented response must match the oldest expectation; idle bus must be quiet.
  always @(negedge pclk) begin
    if (!preset) begin
      if (apb.pready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pready", 64'(apb.pready), 64'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check("resp_prdata", 64'(apb.prdata), 64'(e.data));
          check("resp_pslverr", 64'(apb.pslverr), 64'(e.err));
        end
      end else begin
        check("idle_bus_quiet", {apb.prdata, 31'd0, apb.pslverr}, 64'd0);
      end
    end
  end

  task automatic bus_idle();
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pprot   = '0;
    apb.pwdata  = '0;
    apb.pstrb   = '0;
    cvalid      = 1'b0;
    crdata      = '0;
    cerr        = 1'b0;
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_addr"}, 64'(s_addr), 64'd0);
    check({tag, "_prot"}, 64'(s_prot), 64'd0);
    check({tag, "_rw"}, 64'(s_rw), 64'd0);
    check({tag, "_wdata"}, 64'(s_wdata), 64'd0);
    check({tag, "_strb"}, 64'(s_strb), 64'd0);
    check({tag, "_rdy"}, 64'(s_rdy), 64'd0);
    check({tag, "_bus"}, {apb.prdata, 30'd0, apb.pready, apb.pslverr}, 64'd0);
  endtask

  task automatic check_req(input string tag, input logic [AW-1:0] a, input logic [2:0] p,
                           input logic w, input logic [DW-1:0] d, input logic [BW-1:0] s);
    check({tag, "_addr"}, 64'(s_addr), 64'(a));
    check({tag, "_prot"}, 64'(s_prot), 64'(p));
    check({tag, "_rw"}, 64'(s_rw), 64'(w));
    check({tag, "_wdata"}, 64'(s_wdata), 64'(d));
    check({tag, "_strb"}, 64'(s_strb), 64'(s));
    check({tag, "_rdy"}, 64'(s_rdy), 64'd1);
  endtask

  // One transfer: setup, `waits` access cycles with valid low (bus fields scrambled), then completion.
  task automatic xfer(input string tag, input logic [AW-1:0] a, input logic [2:0] p,
                      input logic w, input logic [DW-1:0] d, input logic [BW-1:0] s,
                      input int waits, input logic [DW-1:0] rd, input logic er,
                      input logic [BW-1:0] exp_strb);
    resp_t e;
    @(posedge pclk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = w;
    apb.paddr = a; apb.pprot = p; apb.pwdata = d; apb.pstrb = s;
    cvalid = 1'b0; crdata = '0; cerr = 1'b0;
    @(negedge pclk);
    check({tag, "_setup_rdy"}, 64'(s_rdy), 64'd0);
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    for (int i = 0; i < waits; i++) begin
      apb.paddr  = ~a;
      apb.pwdata = ~d;
      @(negedge pclk);
      check_req({tag, "_wait"}, a, p, w, d, exp_strb);
      check({tag, "_wait_pready"}, 64'(apb.pready), 64'd0);
      @(posedge pclk); #1;
    end
    e.err  = er;
    e.data = w ? '0 : rd;
    exp_q.push_back(e);
    cvalid = 1'b1; crdata = rd; cerr = er;
    @(negedge pclk);
    check_req({tag, "_done"}, a, p, w, d, exp_strb);
  endtask

  initial begin
    bus_idle();
    preset = 1'b1;
    @(posedge pclk); #1;
    @(negedge pclk);
    check_outputs_clear("reset");
    @(posedge pclk); #1;
    preset = 1'b0;

    // Write, four wait states, completer error.
    xfer("wr_err", 10'd122, 3'b110, 1'b1, 32'd2772003, 4'hF, 4, 32'hDEAD_BEEF, 1'b1, 4'hF);
    @(posedge pclk); #1; bus_idle();
    @(negedge pclk);
    check("wr_err_rdy_after", 64'(s_rdy), 64'd0);

    // Zero-wait read; strobes driven high must be dropped for a read.
    xfer("rd0", 10'd125, 3'b100, 1'b0, 32'h0, 4'hF, 0, 32'd2772003, 1'b0, 4'h0);
    @(posedge pclk); #1; bus_idle();
    @(negedge pclk);
    check("rd0_rdy_after", 64'(s_rdy), 64'd0);

    // Back-to-back: write completes, read setup in the very next cycle.
    xfer("b2b_wr", 10'd5, 3'b000, 1'b1, 32'hA5A5_0001, 4'b0011, 1, 32'h0, 1'b0, 4'b0011);
    xfer("b2b_rd", 10'd6, 3'b001, 1'b0, 32'h0, 4'b1100, 0, 32'h1234_5678, 1'b0, 4'h0);
    @(posedge pclk); #1; bus_idle();

    // Abort: psel dropped during access with no completion.
    @(posedge pclk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 10'd300; apb.pwdata = 32'h55; apb.pstrb = 4'h1;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    @(negedge pclk);
    check("abort_rdy_access", 64'(s_rdy), 64'd1);
    @(posedge pclk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge pclk);
    check("abort_pready", 64'(apb.pready), 64'd0);
    @(posedge pclk); #1;
    // Access-shaped inputs with valid high from IDLE must not complete anything.
    apb.psel = 1'b1; apb.penable = 1'b1; cvalid = 1'b1; crdata = 32'hFFFF_FFFF;
    @(negedge pclk);
    check("abort_rdy_idle", 64'(s_rdy), 64'd0);
    check("abort_no_pready", 64'(apb.pready), 64'd0);
    @(posedge pclk); #1; bus_idle();

    // Reset in the middle of an access.
    @(posedge pclk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 10'd77; apb.pprot = 3'b011; apb.pwdata = 32'hCAFE; apb.pstrb = 4'hA;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    @(negedge pclk);
    check("midrst_rdy_before", 64'(s_rdy), 64'd1);
    @(posedge pclk); #1;
    preset = 1'b1; bus_idle();
    @(posedge pclk); #1;
    @(negedge pclk);
    check_outputs_clear("midrst");
    preset = 1'b0;

    xfer("post_rst", 10'd1023, 3'b010, 1'b0, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0, 4'h0);
    @(posedge pclk); #1; bus_idle();
    repeat (2) @(posedge pclk);
    #1;

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
